// File: rtl/axis_upsizer.sv
// AXI-Stream width upsizer: packs R = M_BUS_W/S_BUS_W narrow beats into one wide beat.
// A beat with s_last closes the wide beat early; unused upper slots go out as zero with keep 0.
module axis_upsizer #(
  parameter int WORD_W  = 8,
  parameter int S_BUS_W = 8,
  parameter int M_BUS_W = 32
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic                                         s_valid,
  output logic                                         s_ready,
  input  logic [S_BUS_W/WORD_W-1:0][WORD_W-1:0]        s_data,
  input  logic [S_BUS_W/WORD_W-1:0]                    s_keep,
  input  logic                                         s_last,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic [M_BUS_W/WORD_W-1:0][WORD_W-1:0]        m_data,
  output logic [M_BUS_W/WORD_W-1:0]                    m_keep,
  output logic                                         m_last
);

  localparam int S_WORDS = S_BUS_W / WORD_W;
  localparam int M_WORDS = M_BUS_W / WORD_W;
  localparam int R       = M_BUS_W / S_BUS_W;
  localparam int IDX_W   = (R > 1) ? $clog2(R) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(R - 1);

  if ((S_BUS_W % WORD_W) != 0 || (M_BUS_W % S_BUS_W) != 0 || M_BUS_W < S_BUS_W) begin : g_bad_params
    $fatal(1, "axis_upsizer: M_BUS_W must be an integer multiple of S_BUS_W, S_BUS_W of WORD_W");
  end

  logic [IDX_W-1:0]                  idx;
  logic                              accept;
  logic                              completing;
  logic [S_WORDS-1:0][WORD_W-1:0]    beat_data;
  logic [M_WORDS-1:0][WORD_W-1:0]    load_data;
  logic [M_WORDS-1:0]                load_keep;

  assign s_ready    = !m_valid || m_ready;
  assign accept     = s_valid && s_ready;
  assign completing = (idx == LAST_IDX) || s_last;

  // Unkept words are forced to zero so x never reaches the wide bus.
  for (genvar gi = 0; gi < S_WORDS; gi++) begin : g_mask
    assign beat_data[gi] = s_keep[gi] ? s_data[gi] : '0;
  end

  for (genvar gi = 0; gi < R; gi++) begin : g_slot
    localparam logic [IDX_W-1:0] SLOT = IDX_W'(gi);
    localparam int LO = gi * S_WORDS;

    if (gi < R - 1) begin : g_held
      logic [S_WORDS-1:0][WORD_W-1:0] slot_data;
      logic [S_WORDS-1:0]             slot_keep;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          slot_data <= '0;
          slot_keep <= '0;
        end else if (accept) begin
          if (completing) begin
            slot_keep <= '0;
          end else if (idx == SLOT) begin
            slot_data <= beat_data;
            slot_keep <= s_keep;
          end
        end
      end

      assign load_data[LO +: S_WORDS] = (idx == SLOT) ? beat_data :
                                        (idx > SLOT)  ? slot_data : '0;
      assign load_keep[LO +: S_WORDS] = (idx == SLOT) ? s_keep :
                                        (idx > SLOT)  ? slot_keep : '0;
    end else begin : g_top
      // The top slot is only ever filled by a completing beat, so it needs no storage.
      assign load_data[LO +: S_WORDS] = (idx == SLOT) ? beat_data : '0;
      assign load_keep[LO +: S_WORDS] = (idx == SLOT) ? s_keep : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx     <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_keep  <= '0;
      m_data  <= '0;
    end else begin
      if (accept) begin
        idx <= completing ? '0 : idx + 1'b1;
      end
      if (accept && completing) begin
        m_valid <= 1'b1;
        m_data  <= load_data;
        m_keep  <= load_keep;
        m_last  <= s_last;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/axis_upsizer.md
# axis_upsizer

AXI-Stream width upsizer. Packs narrow beats from the AXIS producer side into wide beats for the downstream consumer. Preserves packet boundaries: each s_last closes the current wide beat, even if only partly filled. Sits between an AXIS source of width S_BUS_W and any wider AXIS consumer. It is checked with the team's randomized AXIS source/sink models on both sides.

## Interface
Parameters:
- WORD_W, 8, bits per word (keep granularity)
- S_BUS_W, 8, input bus width; multiple of WORD_W
- M_BUS_W, 32, output bus width; integer multiple of S_BUS_W (ratio R = M_BUS_W/S_BUS_W ≥ 1; elaboration $fatal otherwise)
- Derived: S_WORDS = S_BUS_W/WORD_W, M_WORDS = M_BUS_W/WORD_W

Ports:
- clk  in  1  clock; all state on rising edge
- rstn  in  1  reset; asynchronous, active-low
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  [S_WORDS][WORD_W]  input words; word 0 is lowest
- s_keep  in  S_WORDS  per-word valid; contiguous from bit 0; may be partial only when s_last=1
- s_last  in  1  final beat of packet
- m_valid  out  1  registered
- m_ready  in  1  downstream ready
- m_data  out  [M_WORDS][WORD_W]  registered
- m_keep  out  M_WORDS  registered
- m_last  out  1  registered

## Operation
- Slot counter idx counts 0..R-1 and has width max(1,$clog2(R)). Input beat k of a packet lands in slot (k mod R). Slot j covers output words j*S_WORDS .. j*S_WORDS+S_WORDS-1.
- Assembly register holds slots 0..R-2 with their keep bits.
- On an accepted beat:
  - Write s_data and s_keep into slot idx.
  - Input words whose s_keep bit is 0 are stored as 0, so that x does not propagate.
- A beat is completing when idx == R-1 or s_last=1. On an accepted completing beat:
  - The output register loads the assembled slots, with the current beat in slot idx.
  - Slots above idx load data 0 and keep 0.
  - m_last loads s_last. m_valid is set to 1.
  - idx returns to 0 and the assembly keep is cleared.
- On an accepted non-completing beat, idx increments.
- s_ready = !m_valid || m_ready. It is combinational and does not depend on s_valid.
- Output handshake:
  - When m_valid && m_ready and no completing beat arrives in the same cycle, m_valid clears next cycle.
  - m_data, m_keep and m_last hold until the next load.
- R=1 case: every beat is completing, so the block behaves as a registered pipeline stage.
- Reset (async assert, at any time):
  - idx=0 and the assembly register is cleared.
  - m_valid=0, m_last=0, m_keep=0, m_data=0.
  - A partial packet in flight is discarded, and no output beat is produced from it.
  - After reset, s_ready=1.

## Timing
- Latency: m_valid rises on the first clk edge after the completing input handshake (1 cycle).
- Throughput: with s_valid and m_ready both always 1, one input beat is accepted per cycle and one wide beat is emitted every R cycles. No bubbles between packets.
- Simultaneous completing input and output handshake in the same cycle:
  - The output register reloads with the new beat and m_valid stays 1.
  - No cycle is lost and no beat is dropped.
- Backpressure: while m_valid=1 and m_ready=0, s_ready=0. The assembly register and idx are frozen, and m_* are stable.
- AXIS rules: once m_valid=1, it and m_data, m_keep and m_last stay stable until m_ready=1.
- Outputs never depend combinationally on s_*. s_ready depends only on m_valid and m_ready.

## Test plan
All scenarios use WORD_W=8, S_BUS_W=8, M_BUS_W=32 (R=4) unless stated.
- Reset: hold rstn=0 for 5 cycles.
  - During reset: m_valid=0, m_keep=0, m_last=0, m_data=0.
  - After release: s_ready=1.
- Full packet: words 0x01..0x08 with s_last on 0x08, s_valid and m_ready always 1. Two output beats are required:
  - 0x04030201, keep 4'b1111, last=0
  - 0x08070605, keep 4'b1111, last=1
  - First m_valid one cycle after the 0x04 handshake.
- Short packets:
  - Packet 0x0A,0x0B,0x0C → one beat 0x000C0B0A, keep 4'b0111, last=1.
  - Single-word packet 0x55 → 0x00000055, keep 4'b0001, last=1.
  - A packet sent back-to-back after the single-word packet starts again at slot 0.
- Backpressure:
  - Hold m_ready=0 for 6 cycles with a completed beat pending. Required: s_ready=0 and m_data stable throughout.
  - Then release m_ready. No words are lost, duplicated or reordered, and the next beat is emitted with no gap.
- Reset mid-packet:
  - Accept 0x11,0x22, then pulse rstn low asynchronously (not clk-aligned).
  - Required: no output beat. The next packet 0x33..0x36 emits 0x36353433, keep 4'b1111.
- Random: 20 packets of 1–100 words at PROB_VALID=20, PROB_READY=10, with R ∈ {1,2,4} and S_BUS_W=16 variants.
  - Each packet is compared word-for-word against a reference queue, with kept words only.
  - m_last count equals the packet count.
